// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_LOCK   = 2'd1,
        ST_FORCED = 2'd2
    } arb_state_e;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int F3_W   = 3;

    localparam logic [F3_W-1:0] BYTE = 3'b000;
    localparam logic [F3_W-1:0] HALF = 3'b001;
    localparam logic [F3_W-1:0] WORD = 3'b010;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU LSU, the DMA/debug master, the arbiter and the SPRAM.
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    logic              c_req_i;
    logic              c_we_i;
    logic [F3_W-1:0]   c_funct3_i;
    logic [ADDR_W-1:0] c_addr_i;
    logic [DATA_W-1:0] c_wdata_i;
    logic              c_gnt_o;
    logic              c_rvalid_o;
    logic [DATA_W-1:0] c_rdata_o;

    logic              d_req_i;
    logic              d_we_i;
    logic              d_lock_i;
    logic [F3_W-1:0]   d_funct3_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [DATA_W-1:0] d_rdata_o;

    logic [F3_W-1:0]   mem_funct3_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_wr_en_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  c_req_i, c_we_i, c_funct3_i, c_addr_i, c_wdata_i,
        output c_gnt_o, c_rvalid_o, c_rdata_o,
        input  d_req_i, d_we_i, d_lock_i, d_funct3_i, d_addr_i, d_wdata_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output mem_funct3_o, mem_addr_o, mem_wdata_o, mem_wr_en_o,
        input  mem_rdata_i
    );

    modport master (
        output c_req_i, c_we_i, c_funct3_i, c_addr_i, c_wdata_i,
        input  c_gnt_o, c_rvalid_o, c_rdata_o,
        output d_req_i, d_we_i, d_lock_i, d_funct3_i, d_addr_i, d_wdata_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  mem_funct3_o, mem_addr_o, mem_wdata_o, mem_wr_en_o,
        output mem_rdata_i
    );

endinterface

// File: rtl/dmem_arb_lock_ctr.sv
// DMA lock beat counter: clears on arbitration re-entry, saturates at LOCK_MAX,
// and flags when the next counted beat will reach LOCK_MAX.
module dmem_arb_lock_ctr
    import dmem_arbiter_pkg::*;
#(
    parameter int LOCK_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic near_max_o
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(LOCK_MAX);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && cnt_q != MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Decoded from the registered count so the FSM never loops through inc_i.
    assign near_max_o = (cnt_q == MAX - 1'b1);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter (CPU / DMA) in front of the single-port data memory.
// Optional: define DMEM_ARB_RR_EN for round-robin conflict resolution in ARB.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int LOCK_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    dmem_arbiter_if.slave  bus
);

    arb_state_e state_q, state_n;
    logic       c_win, d_win;
    logic       c_gnt, d_gnt;
    logic       near_max;
    logic       cnt_inc, cnt_clr;
    logic       rd_c_q, rd_d_q;

`ifdef DMEM_ARB_RR_EN
    logic       last_gnt_q;
`endif

    always_comb begin
        c_win   = 1'b0;
        d_win   = 1'b0;
        state_n = state_q;
        unique case (state_q)
            ST_ARB: begin
                if (bus.c_req_i && bus.d_req_i) begin
`ifdef DMEM_ARB_RR_EN
                    d_win = (last_gnt_q == PORT_C);
                    c_win = ~d_win;
`else
                    c_win = 1'b1;
`endif
                end else begin
                    c_win = bus.c_req_i;
                    d_win = bus.d_req_i;
                end
                if (d_win && bus.d_lock_i) state_n = ST_LOCK;
            end
            ST_LOCK: begin
                if (bus.d_req_i) begin
                    d_win = 1'b1;
                    if (!bus.d_lock_i)  state_n = ST_ARB;
                    else if (near_max)  state_n = bus.c_req_i ? ST_FORCED : ST_ARB;
                end else begin
                    // DMA went idle mid-lock: the port is free, let a waiting CPU in.
                    c_win   = bus.c_req_i;
                    state_n = ST_ARB;
                end
            end
            ST_FORCED: begin
                c_win   = bus.c_req_i;
                state_n = ST_ARB;
            end
            default: state_n = ST_ARB;
        endcase
    end

    assign c_gnt = c_win & rst_ni;
    assign d_gnt = d_win & rst_ni;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= ST_ARB;
        else         state_q <= state_n;
    end

    assign cnt_inc = d_gnt && (state_q == ST_LOCK || bus.d_lock_i);
    assign cnt_clr = (state_n == ST_ARB);

    dmem_arb_lock_ctr #(
        .LOCK_MAX (LOCK_MAX),
        .CNT_W    (CNT_W)
    ) u_lock_ctr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (cnt_clr),
        .inc_i      (cnt_inc),
        .near_max_o (near_max)
    );

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni)    last_gnt_q <= PORT_C;
        else if (c_gnt) last_gnt_q <= PORT_C;
        else if (d_gnt) last_gnt_q <= PORT_D;
    end
`endif

    always_comb begin
        bus.mem_funct3_o = '0;
        bus.mem_addr_o   = '0;
        bus.mem_wdata_o  = '0;
        bus.mem_wr_en_o  = 1'b0;
        if (c_gnt) begin
            bus.mem_funct3_o = bus.c_funct3_i;
            bus.mem_addr_o   = bus.c_addr_i;
            bus.mem_wdata_o  = bus.c_wdata_i;
            bus.mem_wr_en_o  = bus.c_we_i;
        end else if (d_gnt) begin
            bus.mem_funct3_o = bus.d_funct3_i;
            bus.mem_addr_o   = bus.d_addr_i;
            bus.mem_wdata_o  = bus.d_wdata_i;
            bus.mem_wr_en_o  = bus.d_we_i;
        end
    end

    // Fixed one-cycle memory latency: the flag alone routes the returning word.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_c_q <= 1'b0;
            rd_d_q <= 1'b0;
        end else begin
            rd_c_q <= c_gnt & ~bus.c_we_i;
            rd_d_q <= d_gnt & ~bus.d_we_i;
        end
    end

    assign bus.c_gnt_o    = c_gnt;
    assign bus.d_gnt_o    = d_gnt;
    assign bus.c_rvalid_o = rd_c_q & rst_ni;
    assign bus.d_rvalid_o = rd_d_q & rst_ni;
    assign bus.c_rdata_o  = bus.c_rvalid_o ? bus.mem_rdata_i : '0;
    assign bus.d_rdata_o  = bus.d_rvalid_o ? bus.mem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares whenever a grant or rvalid is visible.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    typedef struct packed {
        logic        cg, dg, cv, dv;
        logic [31:0] crd, drd;
        logic [2:0]  f3;
        logic [14:0] a;
        logic        we;
        logic [31:0] wd;
    } obs_t;

    typedef struct {
        string nm;
        int    cyc;
        obs_t  o;
    } exp_t;

    logic   clk_i = 1'b0;
    logic   rst_ni;
    int     cyc = 0;
    int     n_chk = 0;
    int     n_pass = 0;
    logic   done = 1'b0;
    logic   fin_done = 1'b0;
    exp_t   sb[$];
    exp_t   e_m;
    obs_t   act;
    logic [31:0] mem [0:8191];

    dmem_arbiter_if bus();

    dmem_arbiter #(.LOCK_MAX(8), .CNT_W(8)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Simple SPRAM: one-cycle read, read data reflects writes from earlier cycles.
    always @(posedge clk_i) begin
        if (!rst_ni) begin
            mem[1] <= 32'h1234_5678;
            mem[4] <= 32'hAAAA_0010;
            mem[5] <= 32'hBBBB_0014;
        end else if (bus.mem_wr_en_o) begin
            mem[bus.mem_addr_o[14:2]] <= bus.mem_wdata_o;
        end
        bus.mem_rdata_i <= mem[bus.mem_addr_o[14:2]];
    end

    always @(negedge clk_i) begin
        act = {bus.c_gnt_o, bus.d_gnt_o, bus.c_rvalid_o, bus.d_rvalid_o,
               bus.c_rdata_o, bus.d_rdata_o, bus.mem_funct3_o, bus.mem_addr_o,
               bus.mem_wr_en_o, bus.mem_wdata_o};
        if (!rst_ni) begin
            n_chk++;
            if (act.cg | act.dg | act.cv | act.dv)
                $display("FAIL reset_quiet cyc=%0d got gnt_c/gnt_d/rv_c/rv_d=%b%b%b%b want 0000",
                         cyc, act.cg, act.dg, act.cv, act.dv);
            else n_pass++;
        end else if (act.cg | act.dg | act.cv | act.dv) begin
            n_chk++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_event cyc=%0d got %h want no event", cyc, act);
            end else begin
                e_m = sb.pop_front();
                if (e_m.cyc != cyc || e_m.o !== act)
                    $display("FAIL %s cyc=%0d got %h want cyc=%0d %h",
                             e_m.nm, cyc, act, e_m.cyc, e_m.o);
                else n_pass++;
            end
        end
        if (done && !fin_done) begin
            fin_done = 1'b1;
            n_chk++;
            if (sb.size() != 0)
                $display("FAIL sb_drain got %0d pending (next %s cyc=%0d) want 0",
                         sb.size(), sb[0].nm, sb[0].cyc);
            else n_pass++;
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drv_c(input logic req, input logic we, input logic [14:0] a, input logic [31:0] wd);
        bus.c_req_i    = req;
        bus.c_we_i     = we;
        bus.c_funct3_i = WORD;
        bus.c_addr_i   = a;
        bus.c_wdata_i  = wd;
    endtask

    task automatic drv_d(input logic req, input logic we, input logic lock,
                         input logic [14:0] a, input logic [31:0] wd);
        bus.d_req_i    = req;
        bus.d_we_i     = we;
        bus.d_lock_i   = lock;
        bus.d_funct3_i = HALF;
        bus.d_addr_i   = a;
        bus.d_wdata_i  = wd;
    endtask

    task automatic ex(input string nm, input logic cg, input logic dg, input logic cv, input logic dv,
                      input logic [31:0] crd, input logic [31:0] drd, input logic [2:0] f3,
                      input logic [14:0] a, input logic we, input logic [31:0] wd);
        exp_t e;
        e.nm  = nm;
        e.cyc = cyc;
        e.o   = {cg, dg, cv, dv, crd, drd, f3, a, we, wd};
        sb.push_back(e);
    endtask

    // Both ports read in the same cycle from an ARB state whose pointer (if any) is CPU.
    task automatic conflict_reads(input string nm);
        drv_c(Y, N, 15'h0010, 32'h0);
        drv_d(Y, N, N, 15'h0014, 32'h0);
`ifdef DMEM_ARB_RR_EN
        ex(nm, N, Y, N, N, 32'h0, 32'h0, HALF, 15'h0014, N, 32'h0);
        tick;
        drv_d(N, N, N, 15'h0, 32'h0);
        ex(nm, Y, N, N, Y, 32'h0, 32'hBBBB_0014, WORD, 15'h0010, N, 32'h0);
        tick;
        drv_c(N, N, 15'h0, 32'h0);
        ex(nm, N, N, Y, N, 32'hAAAA_0010, 32'h0, 3'd0, 15'h0, N, 32'h0);
        tick;
`else
        ex(nm, Y, N, N, N, 32'h0, 32'h0, WORD, 15'h0010, N, 32'h0);
        tick;
        drv_c(N, N, 15'h0, 32'h0);
        ex(nm, N, Y, Y, N, 32'hAAAA_0010, 32'h0, HALF, 15'h0014, N, 32'h0);
        tick;
        drv_d(N, N, N, 15'h0, 32'h0);
        ex(nm, N, N, N, Y, 32'h0, 32'hBBBB_0014, 3'd0, 15'h0, N, 32'h0);
        tick;
`endif
    endtask

    initial begin
        // Reset with both requesters active: nothing may be granted.
        rst_ni = 1'b0;
        drv_c(Y, N, 15'h0004, 32'h0);
        drv_d(Y, N, N, 15'h0010, 32'h0);
        repeat (3) tick;
        rst_ni = 1'b1;
        drv_c(N, N, 15'h0, 32'h0);
        drv_d(N, N, N, 15'h0, 32'h0);
        tick;

        // Lone CPU read.
        drv_c(Y, N, 15'h0004, 32'h0);
        ex("c_read_gnt", Y, N, N, N, 32'h0, 32'h0, WORD, 15'h0004, N, 32'h0);
        tick;
        drv_c(N, N, 15'h0, 32'h0);
        ex("c_read_rv", N, N, Y, N, 32'h1234_5678, 32'h0, 3'd0, 15'h0, N, 32'h0);
        tick;

        conflict_reads("conflict");

        // Lock released by d_lock_i=0 on beat 3; CPU waits through the lock.
        for (int k = 0; k < 3; k++) begin
            drv_d(Y, Y, (k < 2), 15'(32'h200 + 4 * k), 32'hE000_0000 + 32'(k));
            if (k == 1) drv_c(Y, N, 15'h0010, 32'h0);
            ex("lock_drop", N, Y, N, N, 32'h0, 32'h0, HALF, 15'(32'h200 + 4 * k), Y,
               32'hE000_0000 + 32'(k));
            tick;
        end
        drv_d(N, N, N, 15'h0, 32'h0);
        ex("after_drop", Y, N, N, N, 32'h0, 32'h0, WORD, 15'h0010, N, 32'h0);
        tick;
        drv_c(N, N, 15'h0, 32'h0);
        ex("after_drop_rv", N, N, Y, N, 32'hAAAA_0010, 32'h0, 3'd0, 15'h0, N, 32'h0);
        tick;

        // 12-beat locked write burst, CPU requesting from beat 2: forced release after 8.
        for (int k = 0; k < 8; k++) begin
            drv_d(Y, Y, Y, 15'(32'h100 + 4 * k), 32'hD000_0000 + 32'(k));
            if (k == 1) drv_c(Y, N, 15'h0004, 32'h0);
            ex("lock_burst", N, Y, N, N, 32'h0, 32'h0, HALF, 15'(32'h100 + 4 * k), Y,
               32'hD000_0000 + 32'(k));
            tick;
        end
        drv_d(Y, Y, Y, 15'h0120, 32'hD000_0008);
        ex("forced_cpu", Y, N, N, N, 32'h0, 32'h0, WORD, 15'h0004, N, 32'h0);
        tick;
        drv_c(N, N, 15'h0, 32'h0);
        for (int k = 8; k < 12; k++) begin
            drv_d(Y, Y, (k != 11), 15'(32'h100 + 4 * k), 32'hD000_0000 + 32'(k));
            ex("burst_resume", N, Y, (k == 8), N, (k == 8) ? 32'h1234_5678 : 32'h0, 32'h0,
               HALF, 15'(32'h100 + 4 * k), Y, 32'hD000_0000 + 32'(k));
            tick;
        end
        drv_d(N, N, N, 15'h0, 32'h0);
        drv_c(Y, N, 15'h0124, 32'h0);
        ex("burst_rdback", Y, N, N, N, 32'h0, 32'h0, WORD, 15'h0124, N, 32'h0);
        tick;
        drv_c(N, N, 15'h0, 32'h0);
        ex("burst_rdback_rv", N, N, Y, N, 32'hD000_0009, 32'h0, 3'd0, 15'h0, N, 32'h0);
        tick;

        // Reset the cycle after a granted DMA read: its response must be dropped.
        drv_d(Y, N, N, 15'h0014, 32'h0);
        ex("rst_drop_gnt", N, Y, N, N, 32'h0, 32'h0, HALF, 15'h0014, N, 32'h0);
        tick;
        rst_ni = 1'b0;
        drv_c(Y, N, 15'h0004, 32'h0);
        drv_d(Y, N, N, 15'h0010, 32'h0);
        repeat (2) tick;
        rst_ni = 1'b1;
        conflict_reads("post_reset_conflict");

        // Store then load of the same word, back to back.
        drv_c(Y, Y, 15'h0020, 32'hDEAD_BEEF);
        ex("c_write", Y, N, N, N, 32'h0, 32'h0, WORD, 15'h0020, Y, 32'hDEAD_BEEF);
        tick;
        drv_c(Y, N, 15'h0020, 32'h0);
        ex("c_read_after_wr", Y, N, N, N, 32'h0, 32'h0, WORD, 15'h0020, N, 32'h0);
        tick;
        drv_c(N, N, 15'h0, 32'h0);
        ex("c_read_after_wr_rv", N, N, Y, N, 32'hDEAD_BEEF, 32'h0, 3'd0, 15'h0, N, 32'h0);
        tick;

        repeat (2) tick;
        done = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
